systolic_output_collector: RTL and testbench

SYSTOLIC_OUTPUT_COLLECTOR -- requirements
Module: systolic_output_collector

---
 rtl/systolic_output_collector.sv | 142 ++++++++++++++
 tb/tb_systolic_output_collector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_collector.sv
// Deskews the bottom-edge psums of an NxN systolic array into aligned rows and buffers them in a small FIFO.
// Define COLLECTOR_RELU_EN to clamp negative column values to zero as rows enter the FIFO.
module systolic_output_collector #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [15:0]                               tile_rows,
    input  logic                                      in_valid,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] psum_in_flat,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data_flat,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overflow
);
    localparam int N   = SYSTOLIC_SIZE;
    localparam int PSW = PARTIAL_SUM_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_e;

    state_e                  state_q;
    logic [15:0]             tile_rows_q, row_cnt_q, row_cnt_d;
    logic [N-2:0]            mk_q;
    logic                    done_q, overflow_q;
    logic [AW:0]             wr_ptr_q, rd_ptr_q, cnt_q;
    logic [N*PSW-1:0]        mem_q [FIFO_DEPTH];
    logic [N-1:0][PSW-1:0]   psum_in, aligned_row, wr_row;
    logic [15:0]             inflight;
    logic [16:0]             inj_total;
    logic                    inj, aln, empty, full, pop, push, drop, empty_d;

    assign psum_in = psum_in_flat;

    // Column j waits N-1-j cycles so every column of a row lines up with column N-1.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int DLY = N - 1 - j;
        if (DLY == 0) begin : g_pass
            assign aligned_row[j] = psum_in[j];
        end else begin : g_dly
            logic [DLY-1:0][PSW-1:0] dly_q;
            always_ff @(posedge clk) begin
                dly_q[0] <= psum_in[j];
                for (int k = 1; k < DLY; k++) dly_q[k] <= dly_q[k-1];
            end
            assign aligned_row[j] = dly_q[DLY-1];
        end
`ifdef COLLECTOR_RELU_EN
        assign wr_row[j] = aligned_row[j][PSW-1] ? '0 : aligned_row[j];
`else
        assign wr_row[j] = aligned_row[j];
`endif
    end

    // The single row counter tracks aligned rows; rows still in the marker pipe make up the injected count.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < N-1; k++) inflight = inflight + {15'd0, mk_q[k]};
    end

    assign inj_total = {1'b0, row_cnt_q} + {1'b0, inflight};
    assign inj       = (state_q == S_COLLECT) && in_valid && (inj_total < {1'b0, tile_rows_q});
    assign aln       = mk_q[N-2];

    assign cnt_q   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop     = !empty && out_ready;
    assign push    = aln && (!full || pop);
    assign drop    = aln && full && !pop;
    assign empty_d = !push && (cnt_q == {{AW{1'b0}}, pop});

    always_comb begin
        row_cnt_d = row_cnt_q;
        if (aln && (row_cnt_q < tile_rows_q)) row_cnt_d = row_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mk_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            row_cnt_q <= '0;
        end else begin
            mk_q[0] <= inj;
            for (int k = 1; k < N-1; k++) mk_q[k] <= mk_q[k-1];
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (state_q == S_IDLE && start) row_cnt_q <= '0;
            else                            row_cnt_q <= row_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tile_rows_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (drop) overflow_q <= 1'b1;
            case (state_q)
                S_IDLE: if (start) begin
                    overflow_q <= 1'b0;
                    if (tile_rows == 16'd0) begin
                        done_q <= 1'b1;
                    end else begin
                        tile_rows_q <= tile_rows;
                        state_q     <= S_COLLECT;
                    end
                end
                S_COLLECT: if (row_cnt_d == tile_rows_q) state_q <= S_DRAIN;
                S_DRAIN: if (empty_d) begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Once draining, the sole buffered entry is the tile's final kept row.
    assign out_valid     = !empty;
    assign out_data_flat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign out_last      = !empty && (state_q == S_DRAIN) && (cnt_q == (AW+1)'(1));
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_systolic_output_collector.sv
// Randomized bench for systolic_output_collector, scored against a queue-based model of tile behaviour.
module tb_systolic_output_collector;
    localparam int N = 8, PSW = 19, D = 4, FW = N*PSW;

    logic clk = 1'b0, rst, start, in_valid, out_ready;
    logic out_valid, out_last, busy, done, overflow;
    logic [15:0] tile_rows;
    logic [FW-1:0] psum_in_flat, out_data_flat;

    always #5 clk = ~clk;

    systolic_output_collector dut (
        .clk(clk), .rst(rst), .start(start), .tile_rows(tile_rows),
        .in_valid(in_valid), .psum_in_flat(psum_in_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data_flat(out_data_flat),
        .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct { int cyc; logic [FW-1:0] d; } pend_t;

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit hist_v [64];
    logic [FW-1:0] hist_d [64];
    pend_t pend [$];
    logic [FW-1:0] q [$];
    bit m_busy, m_ovf, m_done;
    int m_rows, m_inj, m_aln;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [FW-1:0] relu(input logic [FW-1:0] r);
        logic [FW-1:0] o;
        o = r;
`ifdef COLLECTOR_RELU_EN
        for (int j = 0; j < N; j++) if (o[j*PSW+PSW-1]) o[j*PSW +: PSW] = '0;
`endif
        return o;
    endfunction

    function automatic logic [FW-1:0] rand_row();
        logic [FW-1:0] r;
        for (int j = 0; j < N; j++) r[j*PSW +: PSW] = PSW'($urandom);
        return r;
    endfunction

    task automatic model_clear();
        pend.delete(); q.delete();
        m_busy = 0; m_ovf = 0; m_done = 0; m_rows = 0; m_inj = 0; m_aln = 0;
        for (int i = 0; i < 64; i++) hist_v[i] = 0;
    endtask

    task automatic check_outs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        if (q.size() > 0) begin
            chk("out_data", out_data_flat, q[0]);
            chk("out_last", out_last, q.size() == 1 && m_busy && m_aln == m_rows);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check at the next negedge.
    task automatic step(input bit st, input int tr, input bit iv, input bit rdy,
                        input bit own, input logic [FW-1:0] row);
        logic [FW-1:0] r, p;
        bit pop, acc, busy_pre, collect_pre, drain_pre;
        int k;
        r = own ? row : rand_row();
        hist_v[cyc % 64] = iv;
        hist_d[cyc % 64] = r;
        for (int j = 0; j < N; j++) begin
            k = cyc - j;
            if (k >= 0 && hist_v[k % 64]) p[j*PSW +: PSW] = hist_d[k % 64][j*PSW +: PSW];
            else                          p[j*PSW +: PSW] = PSW'($urandom);
        end
        start = st; tile_rows = tr[15:0]; in_valid = iv; out_ready = rdy; psum_in_flat = p;

        busy_pre    = m_busy;
        collect_pre = m_busy && m_aln < m_rows;
        drain_pre   = m_busy && m_aln == m_rows;
        pop = q.size() > 0 && rdy;
        m_done = 0;
        if (pop) void'(q.pop_front());
        if (pend.size() > 0 && pend[0].cyc == cyc) begin
            acc = (q.size() + (pop ? 1 : 0)) < D || pop;
            if (acc) q.push_back(relu(pend[0].d));
            else     m_ovf = 1;
            m_aln++;
            void'(pend.pop_front());
        end
        if (collect_pre && iv && m_inj < m_rows) begin
            m_inj++;
            pend.push_back('{cyc + N - 1, r});
        end
        if (drain_pre && q.size() == 0) begin m_busy = 0; m_done = 1; end
        if (!busy_pre && st) begin
            m_ovf = 0;
            if (tr == 0) m_done = 1;
            else begin m_busy = 1; m_rows = tr; m_inj = 0; m_aln = 0; end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0, '0);
    endtask

    task automatic run_until_idle(input int rdy_pct);
        int g = 0;
        while (m_busy && g < 300) begin
            step(0, 0, 0, $urandom_range(99) < rdy_pct, 0, '0);
            g++;
        end
        chk("drain_bound", busy, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_data"}, out_data_flat, 0);
    endtask

    initial begin
        logic [FW-1:0] row033, exp033;
        int c1, rows;
        rst = 1; start = 0; tile_rows = 0; in_valid = 0; out_ready = 0; psum_in_flat = '0;
        model_clear();
        repeat (3) @(negedge clk);
        reset_checks("rst_hi");
        rst = 0;
        @(negedge clk);
        reset_checks("rst_rel");

        // One-row tile, column j = j-3: aligned row visible N cycles after in_valid.
        for (int j = 0; j < N; j++) begin
            row033[j*PSW +: PSW] = PSW'(j - 3);
            exp033[j*PSW +: PSW] = (j < 3) ? PSW'(j - 3) : PSW'(j - 3);
`ifdef COLLECTOR_RELU_EN
            if (j < 3) exp033[j*PSW +: PSW] = '0;
`endif
        end
        step(1, 1, 0, 1, 0, '0);
        step(0, 0, 1, 1, 1, row033);
        idle(6, 1);
        chk("lat_early", out_valid, 0);
        idle(1, 1);
        chk("lat_valid", out_valid, 1);
        chk("row033", out_data_flat, exp033);
        chk("last033", out_last, 1);
        idle(1, 1);
        chk("done033", done, 1);
        idle(2, 1);

        // Six rows into a 4-deep FIFO with no consumer: two rows dropped.
        step(1, 6, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, '0);
        idle(10, 0);
        chk("ovf034", overflow, 1);
        chk("busy034", busy, 1);
        run_until_idle(100);
        idle(2, 1);

        // Full FIFO with pop on the push cycle of the fifth row: nothing dropped.
        step(1, 5, 0, 0, 0, '0);
        c1 = cyc;
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, '0);
        while (m_busy && cyc < c1 + 40) step(0, 0, 0, cyc >= c1 + 11, 0, '0);
        chk("ovf035", overflow, 0);
        idle(2, 1);

        // Asynchronous reset with three rows in flight, then a clean two-row tile.
        step(1, 8, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, '0);
        idle(2, 0);
        #2 rst = 1;
        #1 reset_checks("rst_mid");
        model_clear();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        reset_checks("rst_mid_rel");
        step(1, 2, 0, 1, 0, '0);
        step(0, 0, 1, 1, 0, '0);
        step(0, 0, 1, 1, 0, '0);
        run_until_idle(100);
        idle(2, 1);

        // Zero-row tile, and a start pulse mid-collect that must be ignored.
        step(1, 0, 0, 1, 0, '0);
        chk("done_zero", done, 1);
        chk("busy_zero", busy, 0);
        idle(1, 1);
        step(1, 3, 0, 1, 0, '0);
        step(0, 0, 1, 1, 0, '0);
        step(1, 9, 1, 1, 0, '0);
        step(0, 0, 1, 1, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, '0);
        run_until_idle(100);
        idle(2, 1);

        // Random tiles: sparse in_valid, random back-pressure, stray start pulses.
        for (int t = 0; t < 8; t++) begin
            rows = $urandom_range(10, 1);
            step(1, rows, 0, $urandom_range(1), 0, '0);
            for (int g = 0; g < 300 && m_busy && m_aln < m_rows; g++)
                step($urandom_range(19) == 0, $urandom_range(20), $urandom_range(99) < 70,
                     $urandom_range(99) < 50, 0, '0);
            run_until_idle(60);
            idle($urandom_range(3), $urandom_range(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
